// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshakes: one full-adder slice processes
// the operands LSB first over WIDTH cycles, then the result is held until taken.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready and result outputs hold while
    // out_valid_o is high and out_ready_i is low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             last_bit;
    logic             bit_s, bit_c;
    logic [WIDTH-1:0] sum_shift;

    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    assign bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_c     = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB.
    assign sum_shift = (sum_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid_i)  state_d = RUN;
            RUN:     if (last_bit)    state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= bit_c;
                    sum_q   <= sum_shift;
                    cnt_q   <= cnt_q + CW'(1);
                    // Publish on the final slice so the result appears with DONE.
                    if (last_bit) begin
                        sum_o  <= sum_shift;
                        cout_o <= bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for the main scenarios
// and a 1-bit instance for the degenerate width.
module tb_serial_add_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       cin8 = 1'b0, cout8, busy8;
    logic [1:0] state8;

    logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       cin1 = 1'b0, cout1, busy1;
    logic [1:0] state1;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .a_i(a8), .b_i(b8), .cin_i(cin8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .sum_o(sum8), .cout_o(cout8), .busy_o(busy8), .state_o(state8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a1), .b_i(b1), .cin_i(cin1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1),
        .sum_o(sum1), .cout_o(cout1), .busy_o(busy1), .state_o(state1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid8(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [8:0] exp, input string tag);
        a8 = a; b8 = b; cin8 = c;
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        chk({tag, "_busy"}, busy8, 1);
        chk({tag, "_in_ready"}, in_ready8, 0);
        wait_valid8(tag, 8);
        chk({tag, "_result"}, {cout8, sum8}, exp);
        step();
        chk({tag, "_valid_one_cycle"}, out_valid8, 0);
        chk({tag, "_back_idle"}, state8, S_IDLE);
    endtask

    initial begin
        int last_acc, cyc, results;
        logic [8:0] exp;
        logic [8:0] held;

        // Reset
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_state", state8, S_IDLE);
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_result", {cout8, sum8}, 9'h000);
        chk("rst_w1_state", state1, S_IDLE);

        // Basic add and carry cases
        run_op8(8'h5A, 8'h3C, 1'b0, 9'h096, "basic");
        run_op8(8'hFF, 8'h01, 1'b0, 9'h100, "carry_ff_01");
        run_op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "carry_ff_ff_1");
        run_op8(8'h00, 8'h00, 1'b1, 9'h001, "carry_00_00_1");

        // Backpressure: hold result in DONE while new operands are offered
        a8 = 8'h80; b8 = 8'h81; cin8 = 1'b1;
        in_valid8 = 1'b1; out_ready8 = 1'b0;
        step();
        wait_valid8("bp", 8);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid8, 1);
            chk("bp_result_held", {cout8, sum8}, 9'h102);
            chk("bp_in_ready", in_ready8, 0);
            chk("bp_state", state8, S_DONE);
            step();
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        step();
        chk("bp_release_state", state8, S_IDLE);
        chk("bp_release_valid", out_valid8, 0);
        chk("bp_result_kept_idle", {cout8, sum8}, 9'h102);
        run_op8(8'h12, 8'h34, 1'b0, 9'h046, "bp_next");

        // Reset during RUN bit 3
        a8 = 8'h77; b8 = 8'h88; cin8 = 1'b1;
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step(); step(); step();
        chk("mid_rst_in_run", state8, S_RUN);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_state", state8, S_IDLE);
        chk("mid_rst_out_valid", out_valid8, 0);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_result", {cout8, sum8}, 9'h000);
        chk("mid_rst_in_ready", in_ready8, 1);
        step(); step(); step(); step(); step(); step(); step(); step();
        chk("mid_rst_no_result", out_valid8, 0);
        run_op8(8'h01, 8'h01, 1'b0, 9'h002, "after_rst");

        // Streaming with both handshakes tied high
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        last_acc = -1; cyc = 0; results = 0;
        while (results < 200 && cyc < 3000) begin
            if (out_valid8) begin
                held = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1xx;
                chk("stream_result", {cout8, sum8}, held);
                results++;
            end
            if (in_ready8 && (exp_q.size() + results) < 200) begin
                if (last_acc >= 0) chk("stream_period", cyc - last_acc, 10);
                last_acc = cyc;
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                cin8 = 1'($urandom_range(0, 1));
                exp = {1'b0, a8} + {1'b0, b8} + {8'h00, cin8};
                exp_q.push_back(exp);
            end
            step();
            cyc++;
        end
        in_valid8 = 1'b0;
        chk("stream_count", results, 200);
        chk("stream_queue_empty", exp_q.size(), 0);

        // WIDTH=1 instance
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        chk("w1_run", state1, S_RUN);
        chk("w1_not_valid_yet", out_valid1, 0);
        step();
        chk("w1_out_valid", out_valid1, 1);
        chk("w1_result", {cout1, sum1}, 2'b11);
        step();
        chk("w1_back_idle", state1, S_IDLE);
        chk("w1_result_held", {cout1, sum1}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are WIDTH >= 1.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid_i, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port in_ready_o, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports a_i and b_i, input, WIDTH bits each: the addend operands.
REQ-007 The block SHALL have port cin_i, input, 1 bit: the carry-in.
REQ-008 The block SHALL have port out_valid_o, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready_i, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port sum_o, output, WIDTH bits: the sum result.
REQ-011 The block SHALL have port cout_o, output, 1 bit: the carry-out result.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement exactly three FSM states: IDLE, RUN and DONE.
REQ-014 The block SHALL decode in_ready_o = (state == IDLE) and out_valid_o = (state == DONE) directly from registered state.
REQ-015 In IDLE, on a rising edge with in_valid_i & in_ready_o, the block SHALL capture a_i, b_i and cin_i into working registers, clear the bit counter, and go to RUN.
- Operands SHALL be sampled only on that accept edge.
REQ-016 In RUN, the block SHALL process one bit per cycle, LSB first, using one full-adder slice.
- s = a ^ b ^ c.
- c_next = (a & b) | ((a ^ b) & c).
- The carry register SHALL update to c_next.
- s SHALL be shifted into the working sum register from the MSB end.
REQ-017 After the WIDTH-th RUN cycle, the block SHALL load sum_o and cout_o from the working registers and go to DONE.
- Latency: out_valid_o SHALL go high exactly WIDTH cycles after the accept edge.
REQ-018 In DONE, sum_o, cout_o and out_valid_o SHALL hold stable until out_valid_o & out_ready_i is sampled; on that edge the block SHALL go to IDLE.
REQ-019 in_ready_o SHALL be 0 in RUN and DONE; in_valid_i asserted in those states SHALL be ignored, with no capture and no state change.
- Minimum back-to-back period: WIDTH+2 cycles.
REQ-020 sum_o and cout_o SHALL change only on the RUN->DONE transition or on reset, and SHALL hold the last result while in IDLE and RUN.
REQ-021 Arithmetic SHALL be {cout_o, sum_o} = a + b + cin, modulo 2^(WIDTH+1), for all operand values.
REQ-022 The bit counter SHALL be wide enough to count to WIDTH without wrap; for WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-023 While rst_n_i is sampled low on a rising edge, the block SHALL set state=IDLE, sum_o=0, cout_o=0 and clear the working and counter registers, from any state.
- Consequence: out_valid_o=0, busy_o=0 and in_ready_o=1 from the following cycle.
REQ-024 Reset SHALL take priority over every handshake sampled on the same edge.
- A reset mid-RUN or mid-DONE SHALL discard the operation, and no result SHALL be presented.

Verification
REQ-025 (WIDTH=8) The bench SHALL cover the basic add and latency case.
- Stimulus: a=0x5A, b=0x3C, cin=0, out_ready_i=1.
- Required response: sum_o=0x96, cout_o=0; out_valid_o high exactly 8 cycles after the accept edge, for one cycle.
REQ-026 The bench SHALL cover the carry cases.
- a=0xFF, b=0x01, cin=0 -> sum_o=0x00, cout_o=1.
- a=0xFF, b=0xFF, cin=1 -> sum_o=0xFF, cout_o=1.
- a=0x00, b=0x00, cin=1 -> sum_o=0x01, cout_o=0.
REQ-027 The bench SHALL cover backpressure.
- Stimulus: out_ready_i held low for 5 cycles in DONE, with in_valid_i high and new operands applied.
- Required response: out_valid_o stays 1; sum_o/cout_o unchanged; in_ready_o=0; no capture.
- After out_ready_i=1: the block returns to IDLE, and the next accept yields the new operands' result.
REQ-028 The bench SHALL cover reset mid-operation.
- Stimulus: rst_n_i=0 for one edge during RUN bit 3.
- Required response: next cycle state IDLE, out_valid_o=0, busy_o=0, sum_o=0x00, cout_o=0, in_ready_o=1.
- A following a=0x01, b=0x01, cin=0 SHALL yield 0x02, cout_o=0.
REQ-029 The bench SHALL cover streaming throughput.
- Stimulus: in_valid_i and out_ready_i tied 1, with randomized operands over 200 transactions.
- Required response: accepts exactly every 10 cycles; every result matches the reference sum a+b+cin.
REQ-030 The bench SHALL cover WIDTH=1.
- Stimulus: a=1, b=1, cin=1.
- Required response: sum_o=1, cout_o=1; out_valid_o high 1 cycle after the accept edge.
